// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory responder for the MAR/MDR interface: latched request,
// WAIT_CYCLES wait states, one-cycle Done pulse. Optional macro: MEM_BOUNDS_CHECK_EN.
module mem_responder #(
   parameter int unsigned ADDR_BITS   = 9,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        Read,
   input  logic        Write,
   input  logic [31:0] MAR,
   input  logic [31:0] MDRdata,
   output logic [31:0] Mdatain,
   output logic        Done,
   output logic        Busy
`ifdef MEM_BOUNDS_CHECK_EN
   ,
   output logic        AddrErr
`endif
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DEPTH  = 1 << ADDR_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_RELEASE
   } state_e;

   logic [DATA_W-1:0]    mem [DEPTH];

   state_e               state_q,   state_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [ADDR_BITS-1:0] addr_q,    addr_d;
   logic [DATA_W-1:0]    wdata_q,   wdata_d;
   logic                 is_wr_q,   is_wr_d;
   logic                 oob_q,     oob_d;
   logic [DATA_W-1:0]    mdatain_q, mdatain_d;
   logic                 done_q,    done_d;
   logic                 busy_q,    busy_d;
   logic                 addr_err_d;
   logic                 mem_we;
   logic                 mar_oob;

`ifdef MEM_BOUNDS_CHECK_EN
   logic                 addr_err_q;
   assign mar_oob = |MAR[DATA_W-1:ADDR_BITS];
   assign AddrErr = addr_err_q;
`else
   // Upper MAR bits are deliberately dropped: addresses wrap modulo depth.
   logic                 unused_mar_hi;
   assign unused_mar_hi = ^{MAR[DATA_W-1:ADDR_BITS], addr_err_d};
   assign mar_oob       = 1'b0;
`endif

   assign Mdatain = mdatain_q;
   assign Done    = done_q;
   assign Busy    = busy_q;

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      is_wr_d    = is_wr_q;
      oob_d      = oob_q;
      mdatain_d  = mdatain_q;
      done_d     = 1'b0;
      addr_err_d = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (Read || Write) begin
               addr_d  = MAR[ADDR_BITS-1:0];
               wdata_d = MDRdata;
               is_wr_d = Write;
               oob_d   = mar_oob;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d    = S_RESP;
               done_d     = 1'b1;
               addr_err_d = oob_q;
               if (is_wr_q) begin
                  mem_we = !oob_q;
               end else begin
                  mdatain_d = oob_q ? '0 : mem[addr_q];
               end
            end
         end
         S_RESP: begin
            state_d = (Read || Write) ? S_RELEASE : S_IDLE;
         end
         S_RELEASE: begin
            if (!Read && !Write) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_WAIT);
   end

   // State and output registers; clear has priority over every same-edge event.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_wr_q   <= 1'b0;
         oob_q     <= 1'b0;
         mdatain_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
         addr_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         is_wr_q   <= is_wr_d;
         oob_q     <= oob_d;
         mdatain_q <= mdatain_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
`ifdef MEM_BOUNDS_CHECK_EN
         addr_err_q <= addr_err_d;
`endif
      end
   end

   // Storage array is not cleared; an aborted write never reaches it.
   always_ff @(posedge clock) begin
      if (mem_we && !clear) mem[addr_q] <= wdata_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance driven with identical stimulus.
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        clear;
   logic        Read, Write;
   logic [31:0] MAR, MDRdata;
   logic [31:0] mdatain, mdatain_f;
   logic        done, done_f, busy, busy_f;
   logic        addr_err, addr_err_f;

   int n_tests = 0;
   int n_fail  = 0;

   int          dc, nd, nb, dc_f, nd_f, nb_f;
   logic [31:0] rd_at, rd_at_f;
   logic        err_at;

   always #5 clock = ~clock;

   mem_responder #(.ADDR_BITS(9), .WAIT_CYCLES(2)) u_dut (
      .clock(clock), .clear(clear), .Read(Read), .Write(Write), .MAR(MAR),
      .MDRdata(MDRdata), .Mdatain(mdatain), .Done(done), .Busy(busy)
`ifdef MEM_BOUNDS_CHECK_EN
      , .AddrErr(addr_err)
`endif
   );

   mem_responder #(.ADDR_BITS(9), .WAIT_CYCLES(0)) u_fast (
      .clock(clock), .clear(clear), .Read(Read), .Write(Write), .MAR(MAR),
      .MDRdata(MDRdata), .Mdatain(mdatain_f), .Done(done_f), .Busy(busy_f)
`ifdef MEM_BOUNDS_CHECK_EN
      , .AddrErr(addr_err_f)
`endif
   );

`ifndef MEM_BOUNDS_CHECK_EN
   assign addr_err   = 1'b0;
   assign addr_err_f = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Raise a request in cycle 0, change MAR/MDRdata in cycle 1, run 14 cycles.
   // hold==0 drops the request in the slow instance's Done cycle, else after 'hold' cycles.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input int hold, input logic [31:0] mar_late);
      @(negedge clock);
      Read = rd; Write = wr; MAR = addr; MDRdata = data;
      dc = -1; nd = 0; nb = 0; dc_f = -1; nd_f = 0; nb_f = 0;
      rd_at = 'x; rd_at_f = 'x; err_at = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         if (k == 1) begin MAR = mar_late; MDRdata = ~data; end
         if (done) begin
            nd++;
            if (dc < 0) begin dc = k; rd_at = mdatain; err_at = addr_err; end
         end
         if (done_f) begin
            nd_f++;
            if (dc_f < 0) begin dc_f = k; rd_at_f = mdatain_f; end
         end
         if (busy) nb++;
         if (busy_f) nb_f++;
         if ((hold == 0) ? (dc >= 0) : (k >= hold)) begin Read = 1'b0; Write = 1'b0; end
      end
   endtask

   initial begin
      clear = 1'b1; Read = 1'b0; Write = 1'b0; MAR = '0; MDRdata = '0;
      repeat (2) @(negedge clock);
      check("rst_mdatain", mdatain, 32'h0);
      check("rst_done",    32'(done), 32'h0);
      check("rst_busy",    32'(busy), 32'h0);
      check("rst_addrerr", 32'(addr_err), 32'h0);
      check("rst_fast_out", {mdatain_f[29:0], done_f, busy_f}, 32'h0);
      clear = 1'b0;

      // Write then read
      txn(1'b0, 1'b1, 32'h10, 32'h0000000A, 0, 32'h10);
      check("wr_done_cycle", 32'(dc), 32'd4);
      check("wr_done_pulses", 32'(nd), 32'd1);
      check("wr_busy_cycles", 32'(nb), 32'd3);
      check("wr_mdatain_kept", mdatain, 32'h0);
      check("w0_done_cycle", 32'(dc_f), 32'd2);
      check("w0_busy_cycles", 32'(nb_f), 32'd1);
      txn(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h11);
      check("rd_done_cycle", 32'(dc), 32'd4);
      check("rd_data", rd_at, 32'h0000000A);
      check("w0_rd_done_cycle", 32'(dc_f), 32'd2);
      check("w0_rd_data", rd_at_f, 32'h0000000A);

      // Reset abort of a pending write
      txn(1'b0, 1'b1, 32'h20, 32'h0, 0, 32'h20);
      @(negedge clock);
      Write = 1'b1; MAR = 32'h20; MDRdata = 32'h72700000;
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      check("abort_out", {mdatain[29:0], done, busy}, 32'h0);
      check("abort_addrerr", 32'(addr_err), 32'h0);
      check("abort_fast_out", {mdatain_f[29:0], done_f, busy_f}, 32'h0);
      clear = 1'b0; Write = 1'b0;
      repeat (2) @(negedge clock);
      txn(1'b1, 1'b0, 32'h20, 32'h0, 0, 32'h20);
      check("abort_rd_data", rd_at, 32'h0);
      check("abort_w0_rd_data", rd_at_f, 32'h0);

      // Simultaneous Read+Write: write wins, Mdatain untouched
      txn(1'b1, 1'b1, 32'h05, 32'hFFFFFFF6, 0, 32'h05);
      check("rw_done_cycle", 32'(dc), 32'd4);
      check("rw_mdatain_kept", rd_at, 32'h0);
      txn(1'b1, 1'b0, 32'h05, 32'h0, 0, 32'h05);
      check("rw_rd_data", rd_at, 32'hFFFFFFF6);

      // Held request with MAR changed during WAIT
      txn(1'b1, 1'b0, 32'h10, 32'h0, 10, 32'h05);
      check("hold_done_pulses", 32'(nd), 32'd1);
      check("hold_w0_done_pulses", 32'(nd_f), 32'd1);
      check("hold_rd_data", rd_at, 32'h0000000A);
      check("hold_busy_cycles", 32'(nb), 32'd3);

`ifdef MEM_BOUNDS_CHECK_EN
      txn(1'b0, 1'b1, 32'h00000210, 32'h12345678, 0, 32'h00000210);
      check("oob_wr_done_cycle", 32'(dc), 32'd4);
      check("oob_wr_addrerr", 32'(err_at), 32'h1);
      txn(1'b1, 1'b0, 32'h010, 32'h0, 0, 32'h010);
      check("oob_inrange_data", rd_at, 32'h0000000A);
      check("oob_inrange_addrerr", 32'(err_at), 32'h0);
      txn(1'b1, 1'b0, 32'h210, 32'h0, 0, 32'h210);
      check("oob_rd_data", rd_at, 32'h0);
      check("oob_rd_addrerr", 32'(err_at), 32'h1);
`else
      // Address wrap: 0x210 aliases 0x010 with 9 address bits
      txn(1'b0, 1'b1, 32'h00000210, 32'h12345678, 0, 32'h00000210);
      check("wrap_wr_done_cycle", 32'(dc), 32'd4);
      txn(1'b1, 1'b0, 32'h010, 32'h0, 0, 32'h010);
      check("wrap_rd_data", rd_at, 32'h12345678);
      check("wrap_w0_rd_data", rd_at_f, 32'h12345678);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
